gate_selftest: RTL and testbench

Sequential stimulus driver and checker for the NAND/NOR gate unit. On a start pulse it drives all four input vectors (X,Y) into the unit and samples its outputs after a programmable settle time. It compares each sample against a golden model and reports a pass/fail summary.
It sits on the opposite side of the gate unit's interface: it produces the unit's inputs and consumes its outputs. It is used for the lab's on-chip self-test.

---
 rtl/gate_selftest_pkg.sv | 23 ++
 rtl/gate_selftest_if.sv | 36 +++
 rtl/gate_golden_model.sv | 24 ++
 rtl/gate_selftest.sv | 153 +++++++++++++++
 tb/tb_gate_selftest.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/gate_selftest_pkg.sv
// ============================================================================
// Module : gate_selftest_pkg
// Brief  : Shared state encoding and sizing for the gate-unit self-test.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package gate_selftest_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int NUM_VECTORS = 4;
  localparam int IDX_W       = 2;

endpackage

`default_nettype wire

// File: rtl/gate_selftest_if.sv
// ============================================================================
// Module : gate_selftest_if
// Brief  : Self-test control/result signals plus the gate-unit stimulus and
//          response wires. The master is the self-test engine.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface gate_selftest_if #(
  parameter int CNT_W = 3
);
  logic             start;
  logic             drv_x;
  logic             drv_y;
  logic             dut_nand;
  logic             dut_nor;
  logic             dut_and;
  logic             dut_or;
  logic             busy;
  logic             done;
  logic             pass;
  logic [3:0]       fail_mask;
  logic [CNT_W-1:0] err_count;

  modport master (
    input  start, dut_nand, dut_nor, dut_and, dut_or,
    output drv_x, drv_y, busy, done, pass, fail_mask, err_count
  );

  modport slave (
    output start, dut_nand, dut_nor, dut_and, dut_or,
    input  drv_x, drv_y, busy, done, pass, fail_mask, err_count
  );
endinterface

`default_nettype wire

// File: rtl/gate_golden_model.sv
// ============================================================================
// Module : gate_golden_model
// Brief  : Combinational reference for the gate unit's four outputs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module gate_golden_model (
  input  wire logic i_x,
  input  wire logic i_y,
  output logic      o_nand,
  output logic      o_nor,
  output logic      o_and,
  output logic      o_or
);

  assign o_and  = i_x & i_y;
  assign o_or   = i_x | i_y;
  assign o_nand = ~(i_x & i_y);
  assign o_nor  = ~(i_x | i_y);

endmodule

`default_nettype wire

// File: rtl/gate_selftest.sv
// ============================================================================
// Module : gate_selftest
// Brief  : Sweeps the four (X,Y) vectors through the gate unit and checks its
//          outputs. Define GATE_SELFTEST_ANDOR_EN to also check AND/OR.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module gate_selftest
  import gate_selftest_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int          CNT_W         = 3
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  gate_selftest_if.master bus
);

  localparam logic [3:0]       c_settleLast = 4'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] c_lastIdx    = IDX_W'(NUM_VECTORS - 1);

  state_t           r_state;
  state_t           w_nextState;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idxNext;
  logic [3:0]       r_settleCnt;
  logic             r_drvX;
  logic             r_drvY;
  logic [3:0]       r_failMask;
  logic [3:0]       w_failMaskNext;
  logic [CNT_W-1:0] r_errCount;
  logic             r_pass;
  logic             w_busy;
  logic             w_done;
  logic             w_mismatch;
  logic             w_expNand;
  logic             w_expNor;
  logic             w_expAnd;
  logic             w_expOr;

  gate_golden_model u_golden (
    .i_x    (r_drvX),
    .i_y    (r_drvY),
    .o_nand (w_expNand),
    .o_nor  (w_expNor),
    .o_and  (w_expAnd),
    .o_or   (w_expOr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: if (bus.start) w_nextState = DRIVE;
      DRIVE: begin
        w_busy      = 1'b1;
        w_nextState = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
      end
      SETTLE: begin
        w_busy = 1'b1;
        if (r_settleCnt == c_settleLast) w_nextState = CHECK;
      end
      CHECK: begin
        w_busy      = 1'b1;
        w_nextState = (r_idx == c_lastIdx) ? DONE : DRIVE;
      end
      DONE: begin
        w_done      = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Unit outputs are only looked at in CHECK so X elsewhere never reaches state.
  always_comb begin
    w_mismatch = 1'b0;
    if (r_state == CHECK) begin
`ifdef GATE_SELFTEST_ANDOR_EN
      w_mismatch = (bus.dut_nand != w_expNand) || (bus.dut_nor != w_expNor) ||
                   (bus.dut_and  != w_expAnd)  || (bus.dut_or  != w_expOr);
`else
      w_mismatch = (bus.dut_nand != w_expNand) || (bus.dut_nor != w_expNor);
`endif
    end
  end

`ifndef GATE_SELFTEST_ANDOR_EN
  logic w_unusedAndOr;
  assign w_unusedAndOr = ^{bus.dut_and, bus.dut_or, w_expAnd, w_expOr};
`endif

  assign w_idxNext      = r_idx + IDX_W'(1);
  assign w_failMaskNext = r_failMask | (w_mismatch ? (4'b0001 << r_idx) : 4'b0000);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_settleCnt <= '0;
      r_drvX      <= 1'b0;
      r_drvY      <= 1'b0;
      r_failMask  <= '0;
      r_errCount  <= '0;
      r_pass      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_idx      <= '0;
            r_drvX     <= 1'b0;
            r_drvY     <= 1'b0;
            r_failMask <= '0;
            r_errCount <= '0;
            r_pass     <= 1'b0;
          end
        end
        DRIVE:  r_settleCnt <= '0;
        SETTLE: r_settleCnt <= r_settleCnt + 4'd1;
        CHECK: begin
          r_failMask <= w_failMaskNext;
          if (w_mismatch && (r_errCount < CNT_W'(NUM_VECTORS)))
            r_errCount <= r_errCount + CNT_W'(1);
          if (r_idx == c_lastIdx) begin
            r_pass <= (w_failMaskNext == 4'b0000);
          end else begin
            r_idx  <= w_idxNext;
            r_drvX <= w_idxNext[1];
            r_drvY <= w_idxNext[0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.drv_x     = r_drvX;
  assign bus.drv_y     = r_drvY;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.pass      = r_pass;
  assign bus.fail_mask = r_failMask;
  assign bus.err_count = r_errCount;

endmodule

`default_nettype wire

// File: tb/tb_gate_selftest.sv
// ============================================================================
// Module : tb_gate_selftest
// Brief  : Directed bench for gate_selftest, with a faultable gate-unit model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gate_selftest;

  localparam int CNT_W = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic sel   = 1'b0;     // 0: SETTLE_CYCLES=2 instance, 1: SETTLE_CYCLES=0 instance
  int   mode  = 0;        // 0 good, 1 nand stuck-1, 2 nand/nor swapped, 3 or stuck-0
  int   nVectors     = 0;
  int   nMiscompares = 0;

  gate_selftest_if #(.CNT_W(CNT_W)) busA ();
  gate_selftest_if #(.CNT_W(CNT_W)) busB ();

  gate_selftest #(.SETTLE_CYCLES(2), .CNT_W(CNT_W)) dutA (.clk(clk), .rst_n(rst_n), .bus(busA));
  gate_selftest #(.SETTLE_CYCLES(0), .CNT_W(CNT_W)) dutB (.clk(clk), .rst_n(rst_n), .bus(busB));

  always #5 clk = ~clk;

  // Gate unit model: returns {nand, nor, and, or}
  function automatic logic [3:0] unitModel(input int m, input logic x, input logic y);
    logic n, r, a, o;
    n = ~(x & y); r = ~(x | y); a = x & y; o = x | y;
    if (m == 1) n = 1'b1;
    if (m == 2) begin n = ~(x | y); r = ~(x & y); end
    if (m == 3) o = 1'b0;
    return {n, r, a, o};
  endfunction

  logic [3:0] gA, gB;
  assign gA = unitModel(mode, busA.drv_x, busA.drv_y);
  assign gB = unitModel(mode, busB.drv_x, busB.drv_y);
  assign {busA.dut_nand, busA.dut_nor, busA.dut_and, busA.dut_or} = gA;
  assign {busB.dut_nand, busB.dut_nor, busB.dut_and, busB.dut_or} = gB;
  assign busA.start = start & ~sel;
  assign busB.start = start & sel;

  logic             mBusy, mDone, mPass, mDx, mDy;
  logic [3:0]       mMask;
  logic [CNT_W-1:0] mErr;
  always_comb begin
    if (sel) {mBusy, mDone, mPass, mDx, mDy, mMask, mErr} =
               {busB.busy, busB.done, busB.pass, busB.drv_x, busB.drv_y, busB.fail_mask, busB.err_count};
    else     {mBusy, mDone, mPass, mDx, mDy, mMask, mErr} =
               {busA.busy, busA.done, busA.pass, busA.drv_x, busA.drv_y, busA.fail_mask, busA.err_count};
  end

  task automatic checkVec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVectors++;
    if (got !== exp) begin
      nMiscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkVec({tag, ".busy"}, 32'(mBusy), 0);
    checkVec({tag, ".done"}, 32'(mDone), 0);
    checkVec({tag, ".pass"}, 32'(mPass), 0);
    checkVec({tag, ".drv"},  32'({mDx, mDy}), 0);
    checkVec({tag, ".mask"}, 32'(mMask), 0);
    checkVec({tag, ".err"},  32'(mErr), 0);
  endtask

  // Acceptance edge T is edge 0; done is visible after edge 4*(2+settle),
  // i.e. cycle T+1+4*(2+settle).
  task automatic runSweep(input string tag, input int settle, input logic rePulse,
                          input logic [3:0] expMask, input int expErr, input logic expPass);
    int doneAt;
    int lastEdge;
    lastEdge = 4 * (2 + settle);
    doneAt   = -1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = rePulse;
    checkVec({tag, ".busyRise"}, 32'(mBusy), 1);
    checkVec({tag, ".drv0"}, 32'({mDx, mDy}), 0);
    for (int k = 1; k <= 40 && doneAt < 0; k++) begin
      @(posedge clk); #1;
      if (mDone) doneAt = k;
      else if (k < lastEdge) checkVec({tag, ".drv"}, 32'({mDx, mDy}), 32'(k / (2 + settle)));
    end
    checkVec({tag, ".doneAt"}, 32'(doneAt), 32'(lastEdge));
    checkVec({tag, ".busyDone"}, 32'(mBusy), 0);
    checkVec({tag, ".pass"}, 32'(mPass), 32'(expPass));
    checkVec({tag, ".mask"}, 32'(mMask), 32'(expMask));
    checkVec({tag, ".err"},  32'(mErr), 32'(expErr));
    checkVec({tag, ".drvLast"}, 32'({mDx, mDy}), 3);
    @(posedge clk); #1 start = 1'b0;
    checkVec({tag, ".donePulse"}, 32'(mDone), 0);
    checkVec({tag, ".maskHeld"}, 32'(mMask), 32'(expMask));
    @(posedge clk); #1;
    checkVec({tag, ".noRestart"}, 32'(mBusy), 0);
    checkVec({tag, ".passHeld"}, 32'(mPass), 32'(expPass));
  endtask

  initial begin
    int sawDone;
    repeat (2) @(posedge clk);
    #1;
    sel = 1'b0; #1 checkAllZero("rstA");
    sel = 1'b1; #1 checkAllZero("rstB");
    sel = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    mode = 0; runSweep("clean",   2, 1'b0, 4'b0000, 0, 1'b1);
    mode = 1; runSweep("nandSA1", 2, 1'b0, 4'b1000, 1, 1'b0);
    mode = 2; runSweep("swap",    2, 1'b0, 4'b0110, 2, 1'b0);

    // Reset during vector-2 SETTLE: vector 1 has already failed by then.
    mode = 2;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 checkVec("midRst.preMask", 32'(mMask), 32'(4'b0010));
    checkVec("midRst.preDrv", 32'({mDx, mDy}), 2);
    #2 rst_n = 1'b0;
    #1 checkAllZero("midRst");
    @(negedge clk) rst_n = 1'b1;
    sawDone = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (mDone) sawDone = 1;
    end
    checkVec("midRst.noDone", 32'(sawDone), 0);
    mode = 0; runSweep("postRst", 2, 1'b0, 4'b0000, 0, 1'b1);

    mode = 1; runSweep("rePulse", 2, 1'b1, 4'b1000, 1, 1'b0);

    sel = 1'b1;
    mode = 0; runSweep("s0clean", 0, 1'b0, 4'b0000, 0, 1'b1);
    mode = 2; runSweep("s0swap",  0, 1'b1, 4'b0110, 2, 1'b0);
    sel = 1'b0;

    mode = 3;
`ifdef GATE_SELFTEST_ANDOR_EN
    runSweep("orSA0", 2, 1'b0, 4'b1110, 3, 1'b0);
`else
    runSweep("orSA0", 2, 1'b0, 4'b0000, 0, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

`default_nettype wire
